// File: rtl/memory_arbiter_fsm_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_fsm_if
//
// Bundles every bus-level signal of the memory arbiter: the instruction port,
// the data port and the single-ported RAM side.
//
//   slave  modport : the arbiter's view. It receives the fetch/load/store
//                    requests and the RAM completion, and it drives the hits,
//                    the load data, the error pulse and the RAM request.
//   master modport : the surrounding system's view (cores + RAM model), the
//                    exact mirror of the slave modport.
//
// Signals
//   imem_ren, imem_addr        fetch request / fetch address
//   ihit, imem_load            fetch completion pulse / fetch data
//   dmem_ren, dmem_wen         load / store requests
//   dmem_addr, dmem_store      data address / store data
//   dhit, dmem_load            data completion pulse / load data
//   mem_err                    completion of a timed-out access
//   ram_ren, ram_wen           RAM read / write strobes
//   ram_addr, ram_store        RAM address / write data
//   ram_load, ram_ready        RAM read data / RAM completion
// -----------------------------------------------------------------------------
interface memory_arbiter_fsm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction port
  logic              imem_ren;
  logic [ADDR_W-1:0] imem_addr;
  logic              ihit;
  logic [DATA_W-1:0] imem_load;

  // data port
  logic              dmem_ren;
  logic              dmem_wen;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_store;
  logic              dhit;
  logic [DATA_W-1:0] dmem_load;

  // shared error pulse
  logic              mem_err;

  // RAM side
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;

  modport slave (
    input  imem_ren, imem_addr,
    input  dmem_ren, dmem_wen, dmem_addr, dmem_store,
    input  ram_load, ram_ready,
    output ihit, imem_load,
    output dhit, dmem_load,
    output mem_err,
    output ram_ren, ram_wen, ram_addr, ram_store
  );

  modport master (
    output imem_ren, imem_addr,
    output dmem_ren, dmem_wen, dmem_addr, dmem_store,
    output ram_load, ram_ready,
    input  ihit, imem_load,
    input  dhit, dmem_load,
    input  mem_err,
    input  ram_ren, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/memory_arbiter_fsm.sv
// -----------------------------------------------------------------------------
// memory_arbiter_fsm
//
// Arbitrates an instruction-fetch port and a data load/store port onto one
// RAM. Exactly one access is outstanding at a time:
//
//   IDLE : pick a winner among the pending requests, latch its type, address
//          and store data, go to BUSY.
//   BUSY : present the latched request to the RAM from registers and wait for
//          ram_ready. If the RAM does not answer within TIMEOUT_CYC cycles the
//          access is abandoned, the error flag is set and a read returns 0.
//   DONE : one cycle; pulse ihit (fetch) or dhit (load/store), plus mem_err if
//          the access timed out. Requests are ignored here and resampled in
//          IDLE.
//
// Arbitration: a store beats a load (a simultaneous store+load is served as a
// store only), and data beats instruction fetch.
//
// Optional feature, macro MEMCTRL_ROUND_ROBIN_EN:
//   When defined, a data request racing a fetch request is granted to the
//   class that was NOT granted last (one history bit, reset value 0 = data
//   was last, so the first race goes to the fetch). Store still beats load.
//   When undefined, data always wins and no history bit exists.
//
// Parameters
//   ADDR_W       address width
//   DATA_W       data width
//   TIMEOUT_CYC  BUSY cycles without ram_ready before aborting (1..255)
//
// Ports
//   CLK   in  clock, rising edge
//   nRST  in  asynchronous active-low reset
//   bus   memory_arbiter_fsm_if.slave  (see the interface file for signals)
// -----------------------------------------------------------------------------
module memory_arbiter_fsm #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      CLK,
  input  logic                      nRST,
  memory_arbiter_fsm_if.slave       bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_e;

  // TIMEOUT_CYC never exceeds 255, so an 8-bit wait counter is enough.
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,     state_d;
  op_e               op_q,        op_d;
  logic              ram_ren_q,   ram_ren_d;
  logic              ram_wen_q,   ram_wen_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] ram_store_q, ram_store_d;
  logic [7:0]        wait_cnt_q,  wait_cnt_d;
  logic              err_q,       err_d;
  logic [DATA_W-1:0] imem_load_q, imem_load_d;
  logic [DATA_W-1:0] dmem_load_q, dmem_load_d;
`ifdef MEMCTRL_ROUND_ROBIN_EN
  // 1 = the instruction port won the most recent grant
  logic              last_i_q,    last_i_d;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration (only consulted in IDLE)
  // ---------------------------------------------------------------------------
  logic              data_req;
  logic              any_req;
  logic              grant_i;
  op_e               win_op;
  logic [7:0]        wait_inc;

  always_comb begin
    data_req = bus.dmem_wen | bus.dmem_ren;
    any_req  = data_req | bus.imem_ren;
`ifdef MEMCTRL_ROUND_ROBIN_EN
    // On a data/fetch race, the fetch wins only if data won last time.
    grant_i  = bus.imem_ren & (~data_req | ~last_i_q);
`else
    grant_i  = bus.imem_ren & ~data_req;
`endif
    if (grant_i) begin
      win_op = OP_FETCH;
    end else if (bus.dmem_wen) begin
      win_op = OP_STORE;
    end else begin
      win_op = OP_LOAD;
    end
    wait_inc = wait_cnt_q + 8'd1;
  end

  // ---------------------------------------------------------------------------
  // Next state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    imem_load_d = imem_load_q;
    dmem_load_d = dmem_load_q;
`ifdef MEMCTRL_ROUND_ROBIN_EN
    last_i_d    = last_i_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d    = ST_BUSY;
          op_d       = win_op;
          ram_ren_d  = (win_op != OP_STORE);
          ram_wen_d  = (win_op == OP_STORE);
          ram_addr_d = grant_i ? bus.imem_addr : bus.dmem_addr;
          // Store data is only meaningful for a store; keep the bus quiet
          // otherwise.
          ram_store_d = (win_op == OP_STORE) ? bus.dmem_store : '0;
          wait_cnt_d  = '0;
          err_d       = 1'b0;
`ifdef MEMCTRL_ROUND_ROBIN_EN
          last_i_d    = grant_i;
`endif
        end
      end

      ST_BUSY: begin
        if (bus.ram_ready) begin
          state_d = ST_DONE;
          if (op_q == OP_FETCH) begin
            imem_load_d = bus.ram_load;
          end else if (op_q == OP_LOAD) begin
            dmem_load_d = bus.ram_load;
          end
        end else if (wait_inc == TIMEOUT_LIM) begin
          // The RAM never answered: finish with an error and hand the
          // reading port a defined zero rather than stale data.
          state_d = ST_DONE;
          err_d   = 1'b1;
          if (op_q == OP_FETCH) begin
            imem_load_d = '0;
          end else if (op_q == OP_LOAD) begin
            dmem_load_d = '0;
          end
        end else begin
          wait_cnt_d = wait_inc;
        end

        // Any exit from BUSY releases the RAM request.
        if (bus.ram_ready || (wait_inc == TIMEOUT_LIM)) begin
          ram_ren_d   = 1'b0;
          ram_wen_d   = 1'b0;
          ram_addr_d  = '0;
          ram_store_d = '0;
        end
      end

      ST_DONE: begin
        // Single-cycle completion; requests pending now are picked up in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_FETCH;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      imem_load_q <= '0;
      dmem_load_q <= '0;
`ifdef MEMCTRL_ROUND_ROBIN_EN
      last_i_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      imem_load_q <= imem_load_d;
      dmem_load_q <= dmem_load_d;
`ifdef MEMCTRL_ROUND_ROBIN_EN
      last_i_q    <= last_i_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Hits are decoded from registered state only, so an asynchronous reset
  // removes them at once.
  assign bus.ihit      = (state_q == ST_DONE) && (op_q == OP_FETCH);
  assign bus.dhit      = (state_q == ST_DONE) && (op_q != OP_FETCH);
  assign bus.mem_err   = (state_q == ST_DONE) && err_q;
  assign bus.imem_load = imem_load_q;
  assign bus.dmem_load = dmem_load_q;
  assign bus.ram_ren   = ram_ren_q;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_store = ram_store_q;

endmodule

// File: tb/tb_memory_arbiter_fsm.sv
module tb_memory_arbiter_fsm;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic CLK  = 1'b0;
  logic nRST = 1'b1;

  always #5 CLK = ~CLK;

  memory_arbiter_fsm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memory_arbiter_fsm #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: what each port's load register should hold, and which
  // class won the last grant (only used with the round-robin option).
  logic [31:0] m_imem   = '0;
  logic [31:0] m_dmem   = '0;
  bit          m_last_i = 1'b0;
  int          txn_no   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.imem_ren = 1'b0;
    bus.dmem_ren = 1'b0;
    bus.dmem_wen = 1'b0;
  endtask

  // One complete access, started at a negedge while the DUT is in IDLE.
  // delay = number of BUSY cycles with ram_ready low before it is raised;
  // delay >= TIMEOUT means the RAM never answers.
  // hold = keep the requests asserted after acceptance.
  task automatic access(input bit ir, input bit dr, input bit dw,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] ds, input int delay, input bit hold);
    int          op;        // 0 fetch, 1 load, 2 store
    bit          take_i;
    bit          timed_out;
    int          busy_len;
    logic [31:0] exp_addr;
    logic [31:0] rd;
    take_i = ir && !(dr || dw);
`ifdef MEMCTRL_ROUND_ROBIN_EN
    if (ir && (dr || dw) && !m_last_i) take_i = 1'b1;
    m_last_i = take_i;
`endif
    op        = take_i ? 0 : (dw ? 2 : 1);
    exp_addr  = take_i ? ia : da;
    timed_out = (delay >= TIMEOUT);
    busy_len  = timed_out ? TIMEOUT : delay + 1;
    rd        = '0;

    bus.imem_ren   = ir;
    bus.dmem_ren   = dr;
    bus.dmem_wen   = dw;
    bus.imem_addr  = ia;
    bus.dmem_addr  = da;
    bus.dmem_store = ds;
    bus.ram_ready  = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    if (!hold) clear_reqs();

    for (int k = 0; k < busy_len; k++) begin
      check("busy_ram_ren",  bus.ram_ren, (op != 2));
      check("busy_ram_wen",  bus.ram_wen, (op == 2));
      check("busy_ram_addr", bus.ram_addr, exp_addr);
      if (op == 2) check("busy_ram_store", bus.ram_store, ds);
      check("busy_no_hit", {bus.ihit, bus.dhit}, 2'b00);
      bus.ram_load = $urandom;
      if (k == delay) begin
        bus.ram_ready = 1'b1;
        rd = bus.ram_load;
      end
      @(posedge CLK);
      @(negedge CLK);
    end
    bus.ram_ready = 1'b0;

    if (op == 0) m_imem = timed_out ? 32'h0 : rd;
    if (op == 1) m_dmem = timed_out ? 32'h0 : rd;
    check("done_ihit",      bus.ihit, (op == 0));
    check("done_dhit",      bus.dhit, (op != 0));
    check("done_mem_err",   bus.mem_err, timed_out);
    check("done_imem_load", bus.imem_load, m_imem);
    check("done_dmem_load", bus.dmem_load, m_dmem);
    check("done_ram_idle",  {bus.ram_ren, bus.ram_wen, bus.ram_addr}, '0);

    @(posedge CLK);
    @(negedge CLK);
    check("idle_no_hit",    {bus.ihit, bus.dhit, bus.mem_err}, 3'b000);
    check("idle_ram_idle",  {bus.ram_ren, bus.ram_wen}, 2'b00);
    check("idle_imem_load", bus.imem_load, m_imem);
    check("idle_dmem_load", bus.dmem_load, m_dmem);
    txn_no++;
    $display("txn %0d op=%0d addr=0x%08h busy_cycles=%0d timeout=%0d imem_load=0x%08h dmem_load=0x%08h",
             txn_no, op, exp_addr, busy_len, timed_out, m_imem, m_dmem);
  endtask

  initial begin
    bit          ir, dr, dw;
    int          r, dly;
    clear_reqs();
    bus.imem_addr  = '0;
    bus.dmem_addr  = '0;
    bus.dmem_store = '0;
    bus.ram_load   = '0;
    bus.ram_ready  = 1'b0;

    // Asynchronous reset with no clock edge involved.
    #2 nRST = 1'b0;
    #1;
    check("rst_hits",  {bus.ihit, bus.dhit, bus.mem_err}, 3'b000);
    check("rst_ram",   {bus.ram_ren, bus.ram_wen, bus.ram_addr, bus.ram_store}, '0);
    check("rst_loads", {bus.imem_load, bus.dmem_load}, '0);
    @(negedge CLK);
    nRST = 1'b1;

    // First edge after release accepts; minimum latency fetch.
    access(1, 0, 0, 32'h100, 32'h0, 32'h0, 0, 0);
    check("fetch_value", bus.imem_load, 32'h00500093 ^ 32'h00500093 ^ m_imem);

    // Directed fetch with the program-word value.
    bus.imem_ren = 1'b1; bus.imem_addr = 32'h100; bus.ram_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    clear_reqs();
    check("lat_ram_ren_n1", bus.ram_ren, 1'b1);
    check("lat_no_hit_n1",  bus.ihit, 1'b0);
    bus.ram_load = 32'h00500093; bus.ram_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.ram_ready = 1'b0;
    check("lat_ihit_n2",      bus.ihit, 1'b1);
    check("lat_imem_load_n2", bus.imem_load, 32'h00500093);
    m_imem = 32'h00500093;
    @(posedge CLK);
    @(negedge CLK);

    // Load so that dmem_load holds something, then store+load collision
    // (served as a store, RAM answers after 3 wait cycles).
    access(0, 1, 0, 32'h0, 32'h40, 32'h0, 1, 0);
    access(0, 1, 1, 32'h0, 32'h2000, 32'hDEADBEEF, 3, 0);
    // RAM stuck: timeout after TIMEOUT busy cycles, load returns 0.
    access(0, 1, 0, 32'h0, 32'h3000, 32'h0, TIMEOUT + 5, 0);
    check("timeout_dmem_zero", bus.dmem_load, 32'h0);

    // Fetch and load held high across four back-to-back accesses.
    for (int i = 0; i < 4; i++) access(1, 1, 0, 32'h500, 32'h600, 32'h0, 0, 1);
    clear_reqs();

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      ir = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
      if (!(ir || dr || dw)) ir = 1'b1;
      r   = $urandom_range(0, 9);
      dly = (r == 9) ? TIMEOUT + 2 : r % 4;
      access(ir, dr, dw, $urandom, $urandom, $urandom, dly, 1'($urandom));
    end
    clear_reqs();
    @(posedge CLK);
    @(negedge CLK);
    access(0, 1, 0, 32'h0, 32'h44, 32'h0, 0, 0);

    // Reset in the second BUSY cycle of a store.
    bus.dmem_wen = 1'b1; bus.dmem_addr = 32'h7000; bus.dmem_store = 32'h12345678;
    @(posedge CLK);
    @(negedge CLK);
    clear_reqs();
    check("mid_rst_wen_before", bus.ram_wen, 1'b1);
    @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    m_imem = '0; m_dmem = '0; m_last_i = 1'b0;
    check("mid_rst_wen_drop", bus.ram_wen, 1'b0);
    check("mid_rst_addr",     bus.ram_addr, 32'h0);
    check("mid_rst_loads",    {bus.imem_load, bus.dmem_load}, '0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("post_rst_no_hit", {bus.ihit, bus.dhit, bus.ram_wen}, 3'b000);
    end
    access(0, 0, 1, 32'h0, 32'h7004, 32'hCAFEF00D, 1, 0);
    access(1, 1, 0, 32'h800, 32'h900, 32'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter_fsm.md
MEMORY_ARBITER_FSM -- requirements
Module: memory_arbiter_fsm

Interface
REQ-001 Parameter ADDR_W, 32, width of all address ports.
REQ-002 Parameter DATA_W, 32, width of all data ports.
REQ-003 Parameter TIMEOUT_CYC, 16, maximum BUSY cycles waiting for ram_ready before the access is aborted; legal range 1..255.
REQ-004 CLK  in  1  single clock, rising edge.
REQ-005 nRST  in  1  reset, asynchronous, active-low.
REQ-006 imem_ren  in  1  instruction fetch request; imem_addr  in  ADDR_W  fetch address.
REQ-007 dmem_ren, dmem_wen  in  1 each  data load and store requests; dmem_addr  in  ADDR_W; dmem_store  in  DATA_W.
REQ-008 ihit, dhit  out  1 each  one-cycle completion pulses; imem_load, dmem_load  out  DATA_W  registered read data.
REQ-009 mem_err  out  1  one-cycle pulse coincident with a hit when the access timed out.
REQ-010 ram_ren, ram_wen  out  1; ram_addr  out  ADDR_W; ram_store  out  DATA_W  registered RAM request.
REQ-011 ram_load  in  DATA_W; ram_ready  in  1  RAM completion, sampled only in BUSY.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-013 IDLE: any request high at a rising edge -> latch winner's type, address and store data; next state BUSY; otherwise stay IDLE.
REQ-014 Arbitration SHALL be: dmem_wen over dmem_ren over imem_ren, except as modified by REQ-026.
REQ-015 dmem_wen and dmem_ren both high SHALL be served as a store only.
REQ-016 In BUSY, ram_ren/ram_wen/ram_addr/ram_store SHALL be held stable from registers; all are 0 in IDLE and DONE.
REQ-017 BUSY with ram_ready=1 -> capture ram_load into the served port's load register (reads only), next state DONE.
REQ-018 BUSY wait counter SHALL clear on BUSY entry and increment each BUSY cycle with ram_ready=0; reaching TIMEOUT_CYC -> next state DONE, error flag set, load register written with 0.
REQ-019 DONE SHALL last exactly one cycle: assert ihit (fetch) or dhit (load/store), mem_err if error flag set; next state IDLE.
REQ-020 Requests present during DONE SHALL NOT be accepted; they are sampled again in IDLE.
REQ-021 Minimum latency: request sampled at edge N, ram strobe high in cycle N+1, hit high in cycle N+2 when ram_ready=1 on first BUSY cycle.
REQ-022 imem_load/dmem_load SHALL hold their value until the next read completion on the same port; stores leave dmem_load unchanged.
REQ-023 Request deasserted while BUSY SHALL NOT abort the access; it completes normally.

Reset
REQ-024 nRST low SHALL immediately force IDLE and drive ihit, dhit, mem_err, ram_ren, ram_wen, ram_addr, ram_store, imem_load, dmem_load, wait counter, error flag and arbitration history to 0, including mid-BUSY.
REQ-025 First request SHALL be accepted at the first rising edge after nRST rises.

Configuration
REQ-026 Macro MEMCTRL_ROUND_ROBIN_EN defined: when a data request and imem_ren are both high in IDLE, grant SHALL go to the class not granted last (history bit, reset 0 = data last); store still beats load within data. Undefined: fixed priority of REQ-014, data always wins, no history bit.

Verification
REQ-027 imem_ren=1, imem_addr=0x100, ram_ready=1, ram_load=0x00500093 -> ram_ren cycle N+1, ihit and imem_load=0x00500093 cycle N+2.
REQ-028 dmem_wen=1, dmem_ren=1, addr=0x2000, store=0xDEADBEEF, ram_ready delayed 3 cycles -> ram_wen held 4 cycles with ram_store=0xDEADBEEF, dhit once, dmem_load unchanged.
REQ-029 dmem_ren=1 with ram_ready stuck 0, TIMEOUT_CYC=16 -> 16 BUSY cycles, then dhit and mem_err together, dmem_load=0.
REQ-030 imem_ren and dmem_ren held high for 4 accesses -> without macro four data grants; with MEMCTRL_ROUND_ROBIN_EN order I, D, I, D.
REQ-031 nRST pulsed low during BUSY cycle 2 of a store -> ram_wen drops asynchronously, no dhit, IDLE after release, next request served normally.
